// File: rtl/fftram_arbiter_if.sv
// Read-port bundle between the FFT result RAM, its two readers and the arbiter.
// The arbiter takes the slave view; the requesters/RAM side takes the master view.
interface fftram_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 28
);
    logic              fftbusy;
    logic              req0;
    logic              req1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic              lock0;
    logic              lock1;
    logic              gnt0;
    logic              gnt1;
    logic [ADDR_W-1:0] ramaddr;
    logic              ramrden;
    logic [DATA_W-1:0] ramq;
    logic [DATA_W-1:0] rdata;
    logic              rvalid0;
    logic              rvalid1;

    modport slave (
        input  fftbusy, req0, req1, addr0, addr1, lock0, lock1, ramq,
        output gnt0, gnt1, ramaddr, ramrden, rdata, rvalid0, rvalid1
    );

    modport master (
        output fftbusy, req0, req1, addr0, addr1, lock0, lock1, ramq,
        input  gnt0, gnt1, ramaddr, ramrden, rdata, rvalid0, rvalid1
    );
endinterface

// File: rtl/fftram_arbiter.sv
// Two-reader arbiter for the FFT result RAM read port: round-robin with a bounded
// sweep lock, blocked while the FFT engine writes, read data routed back by tag.
//
// state | meaning
// IDLE  | no owner; picks the next owner, never grants (one bubble cycle)
// OWN0  | requester 0 (peak-bin sweep) owns the port
// OWN1  | requester 1 (host readback) owns the port
module fftram_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 28,
    parameter int RD_LAT   = 2,
    parameter int MAX_LOCK = 1024
) (
    input  logic            clk,
    input  logic            reset,
    fftram_arbiter_if.slave bus
);
    localparam int LCNT_W = $clog2(MAX_LOCK) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OWN0 = 2'd1;
    localparam logic [1:0] S_OWN1 = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              last_q, last_d;
    logic [LCNT_W-1:0] lcnt_q, lcnt_d;
    logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [RD_LAT-1:0] tag_id_q, tag_id_d;

    logic              gnt0, gnt1, issue0, issue1, rden;
    logic              own_id, req_own, req_oth, lock_own;
    logic [1:0]        st_own, st_oth;
    logic [ADDR_W-1:0] ramaddr;

    // Grants depend only on ownership and fftbusy so a requester can see them before it commits.
    always_comb begin
        gnt0    = (state_q == S_OWN0) && !bus.fftbusy;
        gnt1    = (state_q == S_OWN1) && !bus.fftbusy;
        issue0  = gnt0 && bus.req0;
        issue1  = gnt1 && bus.req1;
        rden    = issue0 || issue1;
        ramaddr = {ADDR_W{1'b0}};
        if (state_q == S_OWN0) begin
            ramaddr = bus.addr0;
        end else if (state_q == S_OWN1) begin
            ramaddr = bus.addr1;
        end
    end

    always_comb begin
        own_id   = (state_q == S_OWN1);
        req_own  = own_id ? bus.req1  : bus.req0;
        req_oth  = own_id ? bus.req0  : bus.req1;
        lock_own = own_id ? bus.lock1 : bus.lock0;
        st_own   = own_id ? S_OWN1 : S_OWN0;
        st_oth   = own_id ? S_OWN0 : S_OWN1;
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        lcnt_d  = lcnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req0 && bus.req1) begin
                    state_d = last_q ? S_OWN0 : S_OWN1;
                end else if (bus.req0) begin
                    state_d = S_OWN0;
                end else if (bus.req1) begin
                    state_d = S_OWN1;
                end
            end
            S_OWN0, S_OWN1: begin
                if (rden) begin
                    last_d = own_id;
                    if (lock_own && (lcnt_q < LCNT_W'(MAX_LOCK - 1))) begin
                        lcnt_d = lcnt_q + LCNT_W'(1);
                    end else begin
                        lcnt_d = '0;
                        if (req_oth) begin
                            state_d = st_oth;
                        end else if (req_own) begin
                            state_d = st_own;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end else if (!bus.fftbusy) begin
                    lcnt_d  = '0;
                    state_d = req_oth ? st_oth : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                lcnt_d  = '0;
            end
        endcase
    end

    // Tags follow each read through the RAM latency so data returns to its issuer
    // even after ownership moves on or fftbusy rises.
    always_comb begin
        tag_vld_d    = tag_vld_q;
        tag_id_d     = tag_id_q;
        tag_vld_d[0] = rden;
        tag_id_d[0]  = own_id;
        for (int k = 1; k < RD_LAT; k++) begin
            tag_vld_d[k] = tag_vld_q[k-1];
            tag_id_d[k]  = tag_id_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            last_q    <= 1'b1;
            lcnt_q    <= '0;
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            lcnt_q    <= lcnt_d;
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
        end
    end

    assign bus.gnt0    = gnt0;
    assign bus.gnt1    = gnt1;
    assign bus.ramrden = rden;
    assign bus.ramaddr = ramaddr;
    assign bus.rdata   = bus.ramq[DATA_W-1:0];
    assign bus.rvalid0 = tag_vld_q[RD_LAT-1] && !tag_id_q[RD_LAT-1];
    assign bus.rvalid1 = tag_vld_q[RD_LAT-1] &&  tag_id_q[RD_LAT-1];
endmodule

// File: tb/tb_fftram_arbiter.sv
// Directed bench for fftram_arbiter: cycle vectors, data-return scoreboard,
// full 1024-issue lock sweep, lock bound of 4 and asynchronous reset mid-flight.
module tb_fftram_arbiter;
    localparam int RD_LAT = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fftram_arbiter_if #(.ADDR_W(10), .DATA_W(28)) bus_a ();
    fftram_arbiter_if #(.ADDR_W(10), .DATA_W(28)) bus_b ();

    fftram_arbiter #(.ADDR_W(10), .DATA_W(28), .RD_LAT(RD_LAT), .MAX_LOCK(1024)) u_dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );
    fftram_arbiter #(.ADDR_W(10), .DATA_W(28), .RD_LAT(RD_LAT), .MAX_LOCK(4)) u_dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [27:0] ramf(input logic [9:0] a);
        return {a, ~a, 8'h5A};
    endfunction

    // RAM model with two-edge read latency
    logic [27:0] ram_p1;
    always @(posedge clk) begin
        ram_p1     <= ramf(bus_a.ramaddr);
        bus_a.ramq <= ram_p1;
    end

    typedef struct {
        int          due;
        logic        id;
        logic [27:0] data;
    } exp_t;
    exp_t sbq[$];
    int   cyc = 0;
    logic sb_en = 1'b0;

    always @(negedge clk) begin
        if (sb_en) begin
            cyc++;
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                chk("rvalid0", 32'(bus_a.rvalid0), 32'(!sbq[0].id));
                chk("rvalid1", 32'(bus_a.rvalid1), 32'(sbq[0].id));
                chk("rdata", 32'(bus_a.rdata), 32'(sbq[0].data));
                void'(sbq.pop_front());
            end else begin
                chk("rvalid0_idle", 32'(bus_a.rvalid0), 32'd0);
                chk("rvalid1_idle", 32'(bus_a.rvalid1), 32'd0);
            end
            if (bus_a.ramrden) begin
                sbq.push_back('{cyc + RD_LAT, bus_a.gnt1, ramf(bus_a.ramaddr)});
            end
        end
    end

    typedef struct {
        logic [4:0] ctl;   // fftbusy, req0, req1, lock0, lock1
        logic [9:0] a0;
        logic [9:0] a1;
        logic [2:0] exp_o; // gnt0, gnt1, ramrden
        logic [9:0] exp_addr;
    } vec_t;

    function automatic vec_t mkv(input logic [4:0] c, input logic [9:0] a0, input logic [9:0] a1,
                                 input logic [2:0] o, input logic [9:0] ea);
        vec_t v;
        v.ctl = c; v.a0 = a0; v.a1 = a1; v.exp_o = o; v.exp_addr = ea;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input vec_t v);
        bus_a.fftbusy = v.ctl[4];
        bus_a.req0    = v.ctl[3];
        bus_a.req1    = v.ctl[2];
        bus_a.lock0   = v.ctl[1];
        bus_a.lock1   = v.ctl[0];
        bus_a.addr0   = v.a0;
        bus_a.addr1   = v.a1;
    endtask

    vec_t vecs[22];
    int   n0, n1, gaps, nb, first_b, last_b;
    logic started;
    logic ids_b[20];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mkv(5'b00000, 10'h000, 10'h000, 3'b000, 10'h000);
        vecs[1]  = mkv(5'b01000, 10'h155, 10'h000, 3'b000, 10'h000);
        vecs[2]  = mkv(5'b01000, 10'h155, 10'h000, 3'b101, 10'h155);
        vecs[3]  = mkv(5'b00000, 10'h000, 10'h000, 3'b100, 10'h000);
        vecs[4]  = mkv(5'b00000, 10'h000, 10'h000, 3'b000, 10'h000);
        vecs[5]  = mkv(5'b01100, 10'h011, 10'h2A2, 3'b000, 10'h000);
        vecs[6]  = mkv(5'b01100, 10'h011, 10'h2A2, 3'b011, 10'h2A2);
        vecs[7]  = mkv(5'b01100, 10'h012, 10'h2A3, 3'b101, 10'h012);
        vecs[8]  = mkv(5'b01100, 10'h012, 10'h2A4, 3'b011, 10'h2A4);
        vecs[9]  = mkv(5'b01000, 10'h020, 10'h000, 3'b101, 10'h020);
        vecs[10] = mkv(5'b11000, 10'h021, 10'h000, 3'b000, 10'h021);
        vecs[11] = mkv(5'b11000, 10'h021, 10'h000, 3'b000, 10'h021);
        vecs[12] = mkv(5'b01000, 10'h021, 10'h000, 3'b101, 10'h021);
        vecs[13] = mkv(5'b00100, 10'h000, 10'h3FF, 3'b100, 10'h000);
        vecs[14] = mkv(5'b00100, 10'h000, 10'h3FF, 3'b011, 10'h3FF);
        vecs[15] = mkv(5'b00000, 10'h000, 10'h000, 3'b010, 10'h000);
        vecs[16] = mkv(5'b01010, 10'h100, 10'h000, 3'b000, 10'h000);
        vecs[17] = mkv(5'b01110, 10'h100, 10'h200, 3'b101, 10'h100);
        vecs[18] = mkv(5'b01100, 10'h101, 10'h200, 3'b101, 10'h101);
        vecs[19] = mkv(5'b00100, 10'h000, 10'h200, 3'b011, 10'h200);
        vecs[20] = mkv(5'b00000, 10'h000, 10'h000, 3'b010, 10'h000);
        vecs[21] = mkv(5'b00000, 10'h000, 10'h000, 3'b000, 10'h000);

        drive_a(vecs[0]);
        bus_b.fftbusy = 1'b0; bus_b.req0 = 1'b0; bus_b.req1 = 1'b0;
        bus_b.lock0 = 1'b0; bus_b.lock1 = 1'b0;
        bus_b.addr0 = 10'h000; bus_b.addr1 = 10'h000; bus_b.ramq = '0;

        #2 reset = 1'b0;
        sb_en = 1'b1;
        #1;
        chk("rst_gnt0", 32'(bus_a.gnt0), 32'd0);
        chk("rst_gnt1", 32'(bus_a.gnt1), 32'd0);
        chk("rst_ramrden", 32'(bus_a.ramrden), 32'd0);
        chk("rst_ramaddr", 32'(bus_a.ramaddr), 32'd0);
        chk("rst_rvalid", 32'({bus_a.rvalid0, bus_a.rvalid1}), 32'd0);
        chk("rst_b_gnt", 32'({bus_b.gnt0, bus_b.gnt1}), 32'd0);
        step(); step();
        reset = 1'b1;

        // cycle-by-cycle vectors
        for (int i = 0; i < 22; i++) begin
            step();
            drive_a(vecs[i]);
            @(negedge clk);
            chk($sformatf("vec%0d_gnt_rden", i),
                32'({bus_a.gnt0, bus_a.gnt1, bus_a.ramrden}), 32'(vecs[i].exp_o));
            chk($sformatf("vec%0d_ramaddr", i), 32'(bus_a.ramaddr), 32'(vecs[i].exp_addr));
        end

        // full sweep with lock: 1024 contiguous requester-0 issues, then requester 1
        n0 = 0; n1 = 0; gaps = 0; started = 1'b0;
        step();
        bus_a.req0 = 1'b1; bus_a.lock0 = 1'b1; bus_a.addr0 = 10'h000;
        bus_a.addr1 = 10'h2BC;
        for (int c = 0; c < 1200 && n1 == 0; c++) begin
            @(negedge clk);
            if (bus_a.ramrden) begin
                started = 1'b1;
                if (bus_a.gnt0) begin
                    chk("sweep_addr", 32'(bus_a.ramaddr), 32'(n0 % 1024));
                    n0++;
                end else begin
                    chk("handover_addr", 32'(bus_a.ramaddr), 32'h2BC);
                    n1++;
                end
            end else if (started) begin
                gaps++;
            end
            step();
            bus_a.addr0 = 10'(n0 % 1024);
            bus_a.req1  = (n0 >= 10);
            if (n0 >= 1024) begin
                bus_a.req0 = 1'b0;
                bus_a.lock0 = 1'b0;
            end
        end
        chk("sweep_count0", 32'(n0), 32'd1024);
        chk("sweep_count1", 32'(n1), 32'd1);
        chk("sweep_gaps", 32'(gaps), 32'd0);
        bus_a.req0 = 1'b0; bus_a.req1 = 1'b0; bus_a.lock0 = 1'b0;
        repeat (4) step();

        // asynchronous reset between issue and data return
        bus_a.req0 = 1'b1; bus_a.addr0 = 10'h0AA;
        @(negedge clk);
        chk("mr_bubble", 32'({bus_a.gnt0, bus_a.gnt1}), 32'd0);
        step();
        @(negedge clk);
        chk("mr_issue", 32'({bus_a.gnt0, bus_a.ramrden}), 32'b11);
        chk("mr_issue_addr", 32'(bus_a.ramaddr), 32'h0AA);
        step();
        bus_a.req0 = 1'b0;
        #2 reset = 1'b0;
        sbq.delete();
        #1;
        chk("mr_gnt", 32'({bus_a.gnt0, bus_a.gnt1}), 32'd0);
        chk("mr_ramrden", 32'(bus_a.ramrden), 32'd0);
        chk("mr_ramaddr", 32'(bus_a.ramaddr), 32'd0);
        chk("mr_rvalid", 32'({bus_a.rvalid0, bus_a.rvalid1}), 32'd0);
        #2;
        bus_a.req0 = 1'b1; bus_a.req1 = 1'b1;
        bus_a.addr0 = 10'h0BB; bus_a.addr1 = 10'h0CC;
        reset = 1'b1;
        @(negedge clk);
        chk("mr_tie_gnt", 32'({bus_a.gnt0, bus_a.gnt1, bus_a.ramrden}), 32'b101);
        chk("mr_tie_addr", 32'(bus_a.ramaddr), 32'h0BB);
        step();
        bus_a.req0 = 1'b0; bus_a.req1 = 1'b0;
        repeat (4) step();

        // lock bound of 4 on the second instance: 0,0,0,0,1 repeating without bubbles
        bus_b.req0 = 1'b1; bus_b.lock0 = 1'b1; bus_b.req1 = 1'b1;
        bus_b.addr0 = 10'h011; bus_b.addr1 = 10'h022;
        nb = 0; first_b = -1; last_b = -1;
        for (int c = 0; c < 40 && nb < 20; c++) begin
            @(negedge clk);
            if (bus_b.ramrden) begin
                ids_b[nb] = bus_b.gnt1;
                if (first_b < 0) first_b = c;
                last_b = c;
                nb++;
            end
        end
        chk("lock4_count", 32'(nb), 32'd20);
        for (int k = 0; k < nb; k++) begin
            chk($sformatf("lock4_id%0d", k), 32'(ids_b[k]), 32'((k % 5) == 4));
        end
        chk("lock4_span", 32'(last_b - first_b), 32'd19);
        bus_b.req0 = 1'b0; bus_b.req1 = 1'b0; bus_b.lock0 = 1'b0;
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
